// File: rtl/fp_cmp_pkg.sv
// Shared exception/op codes and width helper
// for the pipelined FloPoCo comparator.
package fp_cmp_pkg;

  typedef enum logic [1:0] {
    EXN_ZERO = 2'b00,
    EXN_NORM = 2'b01,
    EXN_INF  = 2'b10,
    EXN_NAN  = 2'b11
  } exn_e;

  typedef enum logic [2:0] {
    OP_GT  = 3'd0,
    OP_GE  = 3'd1,
    OP_LT  = 3'd2,
    OP_LE  = 3'd3,
    OP_EQ  = 3'd4,
    OP_NE  = 3'd5,
    OP_MAX = 3'd6,
    OP_MIN = 3'd7
  } op_e;

  function automatic int fp_w(input int we, input int wf);
    return we + wf + 3;
  endfunction

endpackage

// File: rtl/fp_compare_pipe_if.sv
// Operand-pair / result handshake bundle
// for fp_compare_pipe.
interface fp_compare_pipe_if #(
  parameter int WE    = 11,
  parameter int WF    = 15,
  parameter int TAG_W = 4
) ();
  localparam int W = fp_cmp_pkg::fp_w(WE, WF);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_flag;
  logic             out_unord;
  logic [W-1:0]     out_sel;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag,
    input  out_ready,
    output in_ready,
    output out_valid, out_flag, out_unord,
    output out_sel, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid, out_flag, out_unord,
    input  out_sel, out_tag
  );

endinterface

// File: rtl/fp_cmp_core.sv
// Combinational classify-and-compare of two
// FloPoCo operands: lt/eq/gt plus unordered.
module fp_cmp_core
  import fp_cmp_pkg::*;
#(
  parameter int WE = 11,
  parameter int WF = 15
) (
  input  logic [WE+WF+2:0] a,
  input  logic [WE+WF+2:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             unord
);

  localparam int W = fp_w(WE, WF);
  localparam int M = WE + WF;

  exn_e ea;
  exn_e eb;
  logic neg_a;
  logic neg_b;
  logic mag_eq;
  logic mag_lt;
  logic mag_gt;

  assign ea = exn_e'(a[W-1:W-2]);
  assign eb = exn_e'(b[W-1:W-2]);

  // Zero is unsigned so that +0 == -0.
  always_comb begin
    neg_a  = a[W-3] & (ea != EXN_ZERO);
    neg_b  = b[W-3] & (eb != EXN_ZERO);
    mag_eq = (ea == eb) &
             ((ea != EXN_NORM) |
              (a[M-1:0] == b[M-1:0]));
    mag_lt = (ea < eb) |
             ((ea == EXN_NORM) &
              (eb == EXN_NORM) &
              (a[M-1:0] < b[M-1:0]));
    mag_gt = ~mag_lt & ~mag_eq;
    unord  = (ea == EXN_NAN) | (eb == EXN_NAN);
    lt = 1'b0;
    eq = 1'b0;
    gt = 1'b0;
    if (unord) begin
      lt = 1'b0;
    end else if (neg_a != neg_b) begin
      lt = neg_a;
      gt = neg_b;
    end else begin
      eq = mag_eq;
      lt = neg_a ? mag_gt : mag_lt;
      gt = neg_a ? mag_lt : mag_gt;
    end
  end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage elastic FP comparator with
// relation select, NaN handling and min/max.
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int WE    = 11,
  parameter int WF    = 15,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  fp_compare_pipe_if.slave   io
);

  localparam int W = fp_w(WE, WF);

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_flag_q, s2_flag_d;
  logic             s2_unord_q, s2_unord_d;
  logic [W-1:0]     s2_sel_q, s2_sel_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic         s2_adv;
  logic         s1_load;
  logic         s2_load;
  logic         lt, eq, gt, unord;
  logic         a_nan, b_nan;
  logic         mm_op;
  logic         flag;
  logic [W-1:0] sel;

  assign s2_adv      = io.out_ready | ~s2_valid_q;
  assign io.in_ready = ~s1_valid_q | s2_adv;
  assign s1_load     = io.in_valid & io.in_ready;
  assign s2_load     = s1_valid_q & s2_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    if (io.in_ready) s1_valid_d = io.in_valid;
    if (s1_load) begin
      s1_a_d   = io.in_a;
      s1_b_d   = io.in_b;
      s1_op_d  = op_e'(io.in_op);
      s1_tag_d = io.in_tag;
    end
  end

  fp_cmp_core #(
    .WE (WE),
    .WF (WF)
  ) u_core (
    .a     (s1_a_q),
    .b     (s1_b_q),
    .lt    (lt),
    .eq    (eq),
    .gt    (gt),
    .unord (unord)
  );

  // Unordered min/max keep A unless only A is NaN.
  always_comb begin
    a_nan = s1_a_q[W-1:W-2] == EXN_NAN;
    b_nan = s1_b_q[W-1:W-2] == EXN_NAN;
    mm_op = (s1_op_q == OP_MAX) | (s1_op_q == OP_MIN);
    flag  = 1'b0;
    case (s1_op_q)
      OP_GT:   flag = gt;
      OP_GE:   flag = gt | eq;
      OP_LT:   flag = lt;
      OP_LE:   flag = lt | eq;
      OP_EQ:   flag = eq;
      OP_NE:   flag = ~eq;
      OP_MAX:  flag = unord ? ~(a_nan & ~b_nan) : ~lt;
      OP_MIN:  flag = unord ? ~(a_nan & ~b_nan) : ~gt;
      default: flag = 1'b0;
    endcase
    sel = (mm_op & ~flag) ? s1_b_q : s1_a_q;
  end

  always_comb begin
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_flag_d  = s2_flag_q;
    s2_unord_d = s2_unord_q;
    s2_sel_d   = s2_sel_q;
    s2_tag_d   = s2_tag_q;
    if (s2_load) begin
      s2_flag_d  = flag;
      s2_unord_d = unord;
      s2_sel_d   = sel;
      s2_tag_d   = s1_tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_GT;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_flag_q  <= 1'b0;
      s2_unord_q <= 1'b0;
      s2_sel_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_flag_q  <= s2_flag_d;
      s2_unord_q <= s2_unord_d;
      s2_sel_q   <= s2_sel_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign io.out_valid = s2_valid_q;
  assign io.out_flag  = s2_flag_q;
  assign io.out_unord = s2_unord_q;
  assign io.out_sel   = s2_sel_q;
  assign io.out_tag   = s2_tag_q;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench for fp_compare_pipe: directed,
// elastic, reset and parameter-sweep scenarios.
module tb_fp_compare_pipe;

  localparam int WD = 29;
  localparam int WS = 34;
  localparam int WH = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fp_compare_pipe_if #(.WE(11), .WF(15), .TAG_W(4)) dif ();
  fp_compare_pipe_if #(.WE(8),  .WF(23), .TAG_W(4)) sif ();
  fp_compare_pipe_if #(.WE(5),  .WF(10), .TAG_W(4)) hif ();

  fp_compare_pipe #(.WE(11), .WF(15), .TAG_W(4)) u_d (
    .clk(clk), .rst(rst), .io(dif));
  fp_compare_pipe #(.WE(8), .WF(23), .TAG_W(4)) u_s (
    .clk(clk), .rst(rst), .io(sif));
  fp_compare_pipe #(.WE(5), .WF(10), .TAG_W(4)) u_h (
    .clk(clk), .rst(rst), .io(hif));

  typedef struct packed {
    bit flag;
    bit unord;
    bit pick_b;
  } exp_t;

  typedef struct packed {
    logic          flag;
    logic          unord;
    logic [WD-1:0] sel;
    logic [3:0]    tag;
  } dres_t;

  typedef struct {
    logic [WD-1:0] a;
    logic [WD-1:0] b;
    int            op;
    bit            flag;
    bit            unord;
    bit            sel_b;
  } dvec_t;

  // Reference: map each value onto a signed integer line.
  function automatic logic [1:0] exc_of(
    input logic [63:0] x, input int we, input int wf);
    return 2'(x >> (we + wf + 1));
  endfunction

  function automatic longint key_of(
    input logic [63:0] x, input int we, input int wf);
    longint mag;
    logic [63:0] m;
    m = x & ((64'd1 << (we + wf)) - 64'd1);
    case (exc_of(x, we, wf))
      2'd0:    mag = 0;
      2'd1:    mag = 1 + longint'(m);
      default: mag = (longint'(1) << (we + wf)) + 1;
    endcase
    if (x[we+wf]) mag = -mag;
    return mag;
  endfunction

  function automatic exp_t model(
    input logic [63:0] a, input logic [63:0] b,
    input int we, input int wf, input int op);
    exp_t r;
    bit na, nb;
    longint ka, kb;
    na = exc_of(a, we, wf) == 2'd3;
    nb = exc_of(b, we, wf) == 2'd3;
    r = '0;
    r.unord = na | nb;
    if (r.unord) begin
      if (op == 5) r.flag = 1'b1;
      if (op >= 6) begin
        r.pick_b = na & ~nb;
        r.flag   = ~r.pick_b;
      end
    end else begin
      ka = key_of(a, we, wf);
      kb = key_of(b, we, wf);
      case (op)
        0: r.flag = ka > kb;
        1: r.flag = ka >= kb;
        2: r.flag = ka < kb;
        3: r.flag = ka <= kb;
        4: r.flag = ka == kb;
        5: r.flag = ka != kb;
        6: r.flag = ka >= kb;
        default: r.flag = ka <= kb;
      endcase
      if (op >= 6) r.pick_b = ~r.flag;
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd_fp(input int we, input int wf);
    logic [63:0] e, f, x;
    int unsigned k;
    logic [63:0] exc;
    e = {$urandom, $urandom} & ((64'd1 << we) - 64'd1);
    f = {$urandom, $urandom} & ((64'd1 << wf) - 64'd1);
    k = $urandom_range(0, 7);
    exc = (k == 0) ? 64'd0 : (k <= 5) ? 64'd1 : (k == 6) ? 64'd2 : 64'd3;
    x = (exc << (we + wf + 1)) |
        (64'($urandom_range(0, 1)) << (we + wf)) |
        (e << wf) | f;
    return x;
  endfunction

  function automatic logic [63:0] rnd_b(
    input logic [63:0] a, input int we, input int wf);
    case ($urandom_range(0, 3))
      0:       return a;
      1:       return a ^ (64'd1 << (we + wf));
      2:       return a ^ (64'd1 << $urandom_range(0, we + wf - 1));
      default: return rnd_fp(we, wf);
    endcase
  endfunction

  function automatic logic [WD-1:0] mk(
    input int x, input int s, input int e, input int f);
    return {2'(x), 1'(s), 11'(e), 15'(f)};
  endfunction

  task automatic drive_d(
    input logic [WD-1:0] a, input logic [WD-1:0] b,
    input int op, input int tag);
    dif.in_valid = 1'b1;
    dif.in_a     = a;
    dif.in_b     = b;
    dif.in_op    = 3'(op);
    dif.in_tag   = 4'(tag);
  endtask

  task automatic test_reset;
    #2;
    n_vec++;
    if ({dif.out_valid, dif.out_flag, dif.out_unord,
         dif.out_sel, dif.out_tag} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b f=%b u=%b sel=%h tag=%h want all 0",
               dif.out_valid, dif.out_flag, dif.out_unord,
               dif.out_sel, dif.out_tag);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0",
               dif.in_ready, dif.out_valid);
    end
  endtask

  task automatic test_directed;
    dvec_t t[$];
    logic [WD-1:0] one  = mk(1, 0, 'h3FF, 0);
    logic [WD-1:0] two  = mk(1, 0, 'h400, 0);
    logic [WD-1:0] m1   = mk(1, 1, 'h3FF, 0);
    logic [WD-1:0] m2   = mk(1, 1, 'h400, 0);
    logic [WD-1:0] pz   = mk(0, 0, 0, 0);
    logic [WD-1:0] nz   = mk(0, 1, 0, 0);
    logic [WD-1:0] jz   = mk(0, 1, 'h123, 'h45);
    logic [WD-1:0] nan  = mk(3, 0, 0, 0);
    logic [WD-1:0] nan2 = mk(3, 1, 5, 7);
    logic [WD-1:0] pinf = mk(2, 0, 0, 0);
    logic [WD-1:0] jinf = mk(2, 0, 'h55, 1);
    logic [WD-1:0] ninf = mk(2, 1, 0, 0);
    logic [WD-1:0] maxn = mk(1, 0, 'h7FF, 'h7FFF);
    logic [WD-1:0] nmax = mk(1, 1, 'h7FF, 'h7FFF);
    logic [WD-1:0] esel;
    t.push_back('{one,  two,  0, 0, 0, 0});
    t.push_back('{one,  two,  2, 1, 0, 0});
    t.push_back('{one,  two,  6, 0, 0, 1});
    t.push_back('{m2,   m1,   0, 0, 0, 0});
    t.push_back('{m2,   m1,   7, 1, 0, 0});
    t.push_back('{pz,   nz,   4, 1, 0, 0});
    t.push_back('{pz,   nz,   7, 1, 0, 0});
    t.push_back('{nan,  one,  0, 0, 1, 0});
    t.push_back('{nan,  one,  4, 0, 1, 0});
    t.push_back('{nan,  one,  5, 1, 1, 0});
    t.push_back('{nan,  one,  6, 0, 1, 1});
    t.push_back('{pinf, pinf, 4, 1, 0, 0});
    t.push_back('{pinf, maxn, 0, 1, 0, 0});
    t.push_back('{one,  one,  6, 1, 0, 0});
    t.push_back('{nz,   pz,   6, 1, 0, 0});
    t.push_back('{one,  nan,  7, 1, 1, 0});
    t.push_back('{nan,  nan2, 7, 1, 1, 0});
    t.push_back('{jz,   pz,   4, 1, 0, 0});
    t.push_back('{ninf, nmax, 2, 1, 0, 0});
    t.push_back('{jinf, pinf, 4, 1, 0, 0});
    t.push_back('{m1,   one,  1, 0, 0, 0});
    t.push_back('{one,  m1,   5, 1, 0, 0});
    t.push_back('{m1,   m1,   3, 1, 0, 0});
    dif.out_ready = 1'b1;
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive_d(t[i].a, t[i].b, t[i].op, i);
      @(posedge clk); #1;
      dif.in_valid = 1'b0;
      n_vec++;
      if (dif.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir_latency[%0d] out_valid=%b after 1 cycle, want 0",
                 i, dif.out_valid);
      end
      @(posedge clk); #1;
      esel = t[i].sel_b ? t[i].b : t[i].a;
      n_vec++;
      if ({dif.out_valid, dif.out_flag, dif.out_unord,
           dif.out_sel, dif.out_tag} !==
          {1'b1, t[i].flag, t[i].unord, esel, 4'(i)}) begin
        n_err++;
        $display("FAIL dir[%0d] op=%0d got v=%b f=%b u=%b sel=%h tag=%h want v=1 f=%b u=%b sel=%h tag=%h",
                 i, t[i].op, dif.out_valid, dif.out_flag, dif.out_unord,
                 dif.out_sel, dif.out_tag, t[i].flag, t[i].unord,
                 esel, 4'(i));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [WD-1:0] qa[16];
    logic [WD-1:0] qb[16];
    int qop[16];
    exp_t e;
    logic [WD-1:0] esel;
    int i;
    dif.out_ready = 1'b1;
    for (int c = 0; c < 19; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if (c >= 2 && c <= 17) begin
        i = c - 2;
        e = model(64'(qa[i]), 64'(qb[i]), 11, 15, qop[i]);
        esel = e.pick_b ? qb[i] : qa[i];
        if ({dif.in_ready, dif.out_valid, dif.out_flag, dif.out_unord,
             dif.out_sel, dif.out_tag} !==
            {1'b1, 1'b1, e.flag, e.unord, esel, 4'(i)}) begin
          n_err++;
          $display("FAIL b2b[%0d] got rdy=%b v=%b f=%b u=%b sel=%h tag=%h want 1 1 %b %b %h %h",
                   i, dif.in_ready, dif.out_valid, dif.out_flag,
                   dif.out_unord, dif.out_sel, dif.out_tag,
                   e.flag, e.unord, esel, 4'(i));
        end
      end else if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_idle c=%0d got v=%b rdy=%b want 0/1",
                 c, dif.out_valid, dif.in_ready);
      end
      if (c < 16) begin
        qa[c]  = WD'(rnd_fp(11, 15));
        qb[c]  = WD'(rnd_b(64'(qa[c]), 11, 15));
        qop[c] = $urandom_range(0, 7);
        drive_d(qa[c], qb[c], qop[c], c);
      end else begin
        dif.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_stall;
    logic [WD-1:0] one = mk(1, 0, 'h3FF, 0);
    logic [WD-1:0] two = mk(1, 0, 'h400, 0);
    logic [2:0] rdy_seq;
    dif.out_ready = 1'b0;
    @(posedge clk); #1;
    drive_d(one, two, 2, 3);
    @(negedge clk);
    rdy_seq[0] = dif.in_ready;
    @(posedge clk); #1;
    drive_d(two, one, 0, 4);
    @(negedge clk);
    rdy_seq[1] = dif.in_ready;
    @(posedge clk); #1;
    drive_d(one, one, 4, 5);
    @(negedge clk);
    rdy_seq[2] = dif.in_ready;
    n_vec++;
    if (rdy_seq !== 3'b011) begin
      n_err++;
      $display("FAIL stall_in_ready got %b want 011 (newest first)", rdy_seq);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      n_vec++;
      if ({dif.in_ready, dif.out_valid, dif.out_flag,
           dif.out_sel, dif.out_tag} !== {1'b0, 1'b1, 1'b1, one, 4'd3}) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got rdy=%b v=%b f=%b sel=%h tag=%h want 0 1 1 %h 3",
                 k, dif.in_ready, dif.out_valid, dif.out_flag,
                 dif.out_sel, dif.out_tag, one);
      end
    end
    @(posedge clk); #1;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({dif.in_ready, dif.out_valid, dif.out_tag} !== {1'b1, 1'b1, 4'd3}) begin
      n_err++;
      $display("FAIL stall_release got rdy=%b v=%b tag=%h want 1 1 3",
               dif.in_ready, dif.out_valid, dif.out_tag);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if ({dif.out_valid, dif.out_flag, dif.out_sel, dif.out_tag} !==
        {1'b1, 1'b1, two, 4'd4}) begin
      n_err++;
      $display("FAIL stall_second got v=%b f=%b sel=%h tag=%h want 1 1 %h 4",
               dif.out_valid, dif.out_flag, dif.out_sel, dif.out_tag, two);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (dif.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_dup got v=%b tag=%h want v=0",
               dif.out_valid, dif.out_tag);
    end
  endtask

  task automatic test_elastic;
    dres_t q[$];
    dres_t cur, hv, e;
    exp_t m;
    bit held = 1'b0;
    int tagc = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [WD-1:0] a, b;
    int op;
    for (int c = 0; c < 700; c++) begin
      if (c >= 400 && q.size() == 0) break;
      @(posedge clk); #1;
      dif.out_ready = pat[c % 4];
      a  = WD'(rnd_fp(11, 15));
      b  = WD'(rnd_b(64'(a), 11, 15));
      op = $urandom_range(0, 7);
      drive_d(a, b, op, tagc);
      dif.in_valid = (c < 400) && ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cur = {dif.out_flag, dif.out_unord, dif.out_sel, dif.out_tag};
      if (held) begin
        n_vec++;
        if (dif.out_valid !== 1'b1 || cur !== hv) begin
          n_err++;
          $display("FAIL elastic_hold c=%0d got v=%b res=%h want 1 %h",
                   c, dif.out_valid, cur, hv);
        end
      end
      held = dif.out_valid && !dif.out_ready;
      hv   = cur;
      if (dif.out_valid && dif.out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL elastic_spurious c=%0d got res=%h want none", c, cur);
        end else begin
          e = q.pop_front();
          if (cur !== e) begin
            n_err++;
            $display("FAIL elastic_result c=%0d got %h want %h", c, cur, e);
          end
        end
      end
      if (dif.in_valid && dif.in_ready) begin
        m = model(64'(a), 64'(b), 11, 15, op);
        q.push_back({m.flag, m.unord, m.pick_b ? b : a, 4'(tagc)});
        tagc++;
      end
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL elastic_drain got %0d outstanding want 0", q.size());
    end
    @(posedge clk); #1;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight;
    logic [WD-1:0] one = mk(1, 0, 'h3FF, 0);
    logic [WD-1:0] two = mk(1, 0, 'h400, 0);
    logic [WD-1:0] nan = mk(3, 0, 0, 0);
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    drive_d(nan, one, 5, 9);
    @(posedge clk); #1;
    drive_d(one, two, 2, 10);
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    n_vec++;
    if (dif.out_valid !== 1'b1 || dif.out_tag !== 4'd9) begin
      n_err++;
      $display("FAIL rstmid_pre got v=%b tag=%h want 1 9",
               dif.out_valid, dif.out_tag);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({dif.out_valid, dif.out_flag, dif.out_unord,
         dif.out_sel, dif.out_tag} !== '0) begin
      n_err++;
      $display("FAIL rstmid_async got v=%b f=%b u=%b sel=%h tag=%h want all 0",
               dif.out_valid, dif.out_flag, dif.out_unord,
               dif.out_sel, dif.out_tag);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (dif.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_stale[%0d] got v=%b tag=%h want v=0",
                 k, dif.out_valid, dif.out_tag);
      end
    end
    drive_d(two, one, 0, 11);
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    n_vec++;
    if (dif.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_early got v=%b want 0", dif.out_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({dif.out_valid, dif.out_flag, dif.out_unord,
         dif.out_sel, dif.out_tag} !== {1'b1, 1'b1, 1'b0, two, 4'd11}) begin
      n_err++;
      $display("FAIL rstmid_next got v=%b f=%b u=%b sel=%h tag=%h want 1 1 0 %h b",
               dif.out_valid, dif.out_flag, dif.out_unord,
               dif.out_sel, dif.out_tag, two);
    end
  endtask

  logic [63:0] sw_sa[1000];
  logic [63:0] sw_sb[1000];
  int          sw_sop[1000];
  logic [63:0] sw_ha[1000];
  logic [63:0] sw_hb[1000];
  int          sw_hop[1000];

  task automatic test_sweep;
    exp_t e;
    logic [WS-1:0] ss;
    logic [WH-1:0] hs;
    int i;
    sif.out_ready = 1'b1;
    hif.out_ready = 1'b1;
    for (int c = 0; c < 1002; c++) begin
      @(posedge clk); #1;
      if (c >= 2) begin
        i = c - 2;
        e  = model(sw_sa[i], sw_sb[i], 8, 23, sw_sop[i]);
        ss = e.pick_b ? WS'(sw_sb[i]) : WS'(sw_sa[i]);
        n_vec++;
        if ({sif.out_valid, sif.out_flag, sif.out_unord,
             sif.out_sel, sif.out_tag} !==
            {1'b1, e.flag, e.unord, ss, 4'(i)}) begin
          n_err++;
          $display("FAIL sweep_8_23[%0d] op=%0d a=%h b=%h got v=%b f=%b u=%b sel=%h want f=%b u=%b sel=%h",
                   i, sw_sop[i], sw_sa[i], sw_sb[i], sif.out_valid,
                   sif.out_flag, sif.out_unord, sif.out_sel,
                   e.flag, e.unord, ss);
        end
        e  = model(sw_ha[i], sw_hb[i], 5, 10, sw_hop[i]);
        hs = e.pick_b ? WH'(sw_hb[i]) : WH'(sw_ha[i]);
        n_vec++;
        if ({hif.out_valid, hif.out_flag, hif.out_unord,
             hif.out_sel, hif.out_tag} !==
            {1'b1, e.flag, e.unord, hs, 4'(i)}) begin
          n_err++;
          $display("FAIL sweep_5_10[%0d] op=%0d a=%h b=%h got v=%b f=%b u=%b sel=%h want f=%b u=%b sel=%h",
                   i, sw_hop[i], sw_ha[i], sw_hb[i], hif.out_valid,
                   hif.out_flag, hif.out_unord, hif.out_sel,
                   e.flag, e.unord, hs);
        end
      end
      if (c < 1000) begin
        sw_sa[c]  = rnd_fp(8, 23);
        sw_sb[c]  = rnd_b(sw_sa[c], 8, 23);
        sw_sop[c] = $urandom_range(0, 7);
        sw_ha[c]  = rnd_fp(5, 10);
        sw_hb[c]  = rnd_b(sw_ha[c], 5, 10);
        sw_hop[c] = $urandom_range(0, 7);
        sif.in_valid = 1'b1;
        sif.in_a     = WS'(sw_sa[c]);
        sif.in_b     = WS'(sw_sb[c]);
        sif.in_op    = 3'(sw_sop[c]);
        sif.in_tag   = 4'(c);
        hif.in_valid = 1'b1;
        hif.in_a     = WH'(sw_ha[c]);
        hif.in_b     = WH'(sw_hb[c]);
        hif.in_op    = 3'(sw_hop[c]);
        hif.in_tag   = 4'(c);
      end else begin
        sif.in_valid = 1'b0;
        hif.in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    dif.in_valid = 1'b0; dif.in_a = '0; dif.in_b = '0;
    dif.in_op = '0; dif.in_tag = '0; dif.out_ready = 1'b1;
    sif.in_valid = 1'b0; sif.in_a = '0; sif.in_b = '0;
    sif.in_op = '0; sif.in_tag = '0; sif.out_ready = 1'b1;
    hif.in_valid = 1'b0; hif.in_a = '0; hif.in_b = '0;
    hif.in_op = '0; hif.in_tag = '0; hif.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_elastic();
    test_reset_midflight();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Parametrised, pipelined comparator for FloPoCo-format floating-point operands (2-bit exception field, sign, WE-bit exponent, WF-bit fraction).
- Successor to the single-flag subtract-based greater-than block. Compares directly without an FP subtractor.
- Supports eight selectable relations, IEEE-style unordered (NaN) handling and a min/max select output.
- Uses a valid/ready elastic pipeline with tag passthrough. Used by the ray/AABB slab tests for tmin/tmax reduction.

Parameters:
WE, 11, exponent width
WF, 15, fraction width
TAG_W, 4, width of the opaque tag carried alongside each operand pair
(derived, not overridable) W = WE+WF+3, full operand width; 29 for the defaults

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept a pair this cycle
in_a  in  W  operand A
in_b  in  W  operand B
in_op  in  3  relation: 0 GT, 1 GE, 2 LT, 3 LE, 4 EQ, 5 NE, 6 MAX, 7 MIN
in_tag  in  TAG_W  user tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_flag  out  1  relation result (MAX: 1 when A chosen; MIN: 1 when A chosen)
out_unord  out  1  either operand NaN
out_sel  out  W  selected operand (MAX/MIN); A for all other ops
out_tag  out  TAG_W  tag of this result

Behaviour:
- Field layout: [W-1:W-2] exception (00 zero, 01 normal, 10 inf, 11 NaN), [W-3] sign, [W-4:WF] exponent, [WF-1:0] fraction.
- Reset (rst=0, asynchronous): both stage valid bits clear; out_valid=0, out_flag=0, out_unord=0, out_sel=0, out_tag=0. in_ready=1 immediately after reset release.
- Pipeline: 2 register stages. Latency is exactly 2 cycles from accept (in_valid&in_ready) to out_valid when not stalled.
  - S1: register operands/op/tag; classify each operand; compute equality of the magnitude fields.
  - S2: compute the final relation and out_sel.
- Handshake:
  - Stage k loads when its upstream is valid and (stage k empty, or stage k advancing).
  - S2 advances on out_ready, or when S2 is empty.
  - in_ready = !s1_valid | s2_advance (full throughput, no bubbles).
  - out_* hold stable while out_valid & !out_ready.
  - Stage data registers do not change when the stage is not loading.
- Ordering key: zero < normal (ordered by exponent‖fraction unsigned) < inf, signed by the sign bit. Negative values reverse the magnitude order.
  - +0 and -0 compare equal.
  - inf equals inf of the same sign.
- Unordered: either exception == 11.
  - out_unord=1.
  - GT/GE/LT/LE/EQ give 0; NE gives 1.
  - MAX/MIN return the non-NaN operand (flag = A chosen); if both are NaN, return A with flag=1.
- MAX/MIN on equal values, including ±0: return A, flag=1.
- Non-canonical inputs: fraction/exponent bits under exception 00/10 are ignored. Out_sel passes the chosen word unmodified.
- Reset mid-operation discards all in-flight pairs. No output is produced for them.

Decomposition:
- Package fp_cmp_pkg:
  - exception codes EXN_ZERO/NORM/INF/NAN.
  - op codes OP_GT..OP_MIN.
  - function fp_w(WE,WF).
- Sub-module fp_cmp_core: combinational classify-and-compare on two operands, producing lt/eq/gt/unord. It is instantiated once, between S1 and S2.
- Top-level fp_compare_pipe holds the elastic pipeline, op decode and select mux. Target is about 200 RTL lines.

Test Plan:
- Defaults; A=1.0 {01,0,0x3FF,0x0000}, B=2.0 {01,0,0x400,0}, op GT -> out_flag=0 at cycle 2. Op LT -> 1. Op MAX -> out_sel=B, flag=0.
- A=-2.0, B=-1.0, op GT -> 0; op MIN -> out_sel=A, flag=1. A=+0 {00,0,..}, B=-0 {00,1,..}, op EQ -> 1; op MIN -> A, flag=1.
- A=NaN {11,..}, B=1.0, ops GT/EQ/NE/MAX -> flags 0/0/1/0, unord=1, MAX out_sel=B. A=+inf vs B=+inf, op EQ -> 1. A=+inf vs B=max normal, op GT -> 1.
- Back-to-back stream of 16 pairs with out_ready=1 -> 16 results in order, one per cycle, tags 0..15 in sequence. Ready toggling 1,0,0,1 -> no loss or duplication; out_* held while stalled; in_ready drops after 2 stalled entries.
- Assert rst=0 with 2 pairs in flight -> out_valid=0 asynchronously, all outputs zero. After release the next pair produces a result 2 cycles later; there are no stale results.
- Parameter sweep WE=8,WF=23 and WE=5,WF=10: 1000 random pairs checked against a reference model of the ordering rules.
